// File: rtl/fpr_wb_pkg.sv
// Shared types for the FP writeback arbiter: writeback packet, port count, data width.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package fpr_wb_pkg;

  localparam int FLEN       = 32;
  localparam int NUM_WPORTS = 2;

  typedef struct packed {
    logic            valid;
    logic [4:0]      addr;
    logic [FLEN-1:0] data;
  } fpr_wb_pkt_t;

  // Builds a writeback packet; f0 is hardwired so a write to it is squashed here.
  function automatic fpr_wb_pkt_t mk_pkt(input logic v, input logic [4:0] a,
                                         input logic [FLEN-1:0] d);
    fpr_wb_pkt_t p;
    p.valid = v && (a != 5'd0);
    p.addr  = a;
    p.data  = d;
    return p;
  endfunction

endpackage

// File: rtl/fpr_wb_fifo.sv
// Load-return FIFO; exposes the two oldest entries so both write ports can drain it in one cycle.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: full is registered; a push while full is accepted only if a pop happens the same cycle.
// Ports: push/push_dat in, pop_cnt (0..2 entries) in, head0/head1 valid+data out, full out.
module fpr_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic [1:0]   pop_cnt,
  output logic         head0_vld,
  output logic [W-1:0] head0_dat,
  output logic         head1_vld,
  output logic [W-1:0] head1_dat,
  output logic         full
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nx;
  logic             push_ok;

  assign head0_vld = (count != '0);
  assign head1_vld = (count > (PTR_W+1)'(1));
  assign head0_dat = mem[rd_ptr];
  assign head1_dat = mem[rd_ptr + PTR_W'(1)];

  // When full, the slot freed by a same-cycle pop is the one the write pointer targets.
  assign push_ok  = push && (!full || (pop_cnt != 2'd0));
  assign count_nx = count - (PTR_W+1)'(pop_cnt) + (PTR_W+1)'(push_ok);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
      wr_ptr <= wr_ptr + PTR_W'(push_ok);
      count  <= count_nx;
      full   <= (count_nx == (PTR_W+1)'(DEPTH));
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_l)
    !(push && full && (pop_cnt == 2'd0)));

endmodule

// File: rtl/dec_fpr_wb_arb.sv
// FP writeback arbiter: merges pipe i0/i1, queued load returns and fdiv/fsqrt into two FPR write ports.
// Latency: one cycle from grant to wen/waddr/wd (output flops); loads reach the regfile >= 2 cycles after arrival.
// Backpressure: div held via combinational div_ready; LSU throttled by registered ld_full.
// Ports: p0_*/p1_* pipe results, div_* divider handshake, ld_* load returns, iss_* long-latency issue,
//        wen*/waddr*/wd* regfile writes, fpr_busy pending-destination scoreboard.
// Option: FPR_WB_SCOREBOARD_EN enables fpr_busy; otherwise it is tied to zero and iss_* are ignored.
module dec_fpr_wb_arb
  import fpr_wb_pkg::*;
#(
  parameter int LDQ_DEPTH = 4,
  parameter int LDQ_PTR_W = 2
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            p0_valid,
  input  logic [4:0]      p0_addr,
  input  logic [FLEN-1:0] p0_data,
  input  logic            p1_valid,
  input  logic [4:0]      p1_addr,
  input  logic [FLEN-1:0] p1_data,
  input  logic            div_valid,
  input  logic [4:0]      div_addr,
  input  logic [FLEN-1:0] div_data,
  output logic            div_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_addr,
  input  logic [FLEN-1:0] ld_data,
  output logic            ld_full,
  output logic            wen0,
  output logic [4:0]      waddr0,
  output logic [FLEN-1:0] wd0,
  output logic            wen1,
  output logic [4:0]      waddr1,
  output logic [FLEN-1:0] wd1,
  output logic [31:1]     fpr_busy,
  input  logic            iss_valid,
  input  logic            iss_ld,
  input  logic [4:0]      iss_addr
);

  localparam int LDQ_W = 5 + FLEN;

  logic             h0_vld, h1_vld;
  logic [LDQ_W-1:0] h0_dat, h1_dat;
  logic [4:0]       h0_addr, h1_addr;
  logic [FLEN-1:0]  h0_data, h1_data;
  logic [1:0]       nfree, ld_n;
  logic             div_gnt;
  logic             p0_kill, h0_kill, h1_kill, div_kill;
  fpr_wb_pkt_t      p0_pkt, p1_pkt, h0_pkt, h1_pkt, div_pkt;
  fpr_wb_pkt_t      cand0, cand1, w0_nx, w1_nx;

  fpr_wb_fifo #(
    .DEPTH (LDQ_DEPTH),
    .PTR_W (LDQ_PTR_W),
    .W     (LDQ_W)
  ) u_ldq (
    .clk       (clk),
    .rst_l     (rst_l),
    .push      (ld_valid),
    .push_dat  ({ld_addr, ld_data}),
    .pop_cnt   (ld_n),
    .head0_vld (h0_vld),
    .head0_dat (h0_dat),
    .head1_vld (h1_vld),
    .head1_dat (h1_dat),
    .full      (ld_full)
  );

  assign {h0_addr, h0_data} = h0_dat;
  assign {h1_addr, h1_data} = h1_dat;

  always_comb begin
    // Pipes own their ports; whatever is left goes to queued loads first, then the divider.
    nfree = 2'(!p0_valid) + 2'(!p1_valid);
    ld_n  = 2'd0;
    if (h0_vld && (nfree != 2'd0)) ld_n = (h1_vld && (nfree == 2'd2)) ? 2'd2 : 2'd1;
    div_gnt = div_valid && (nfree > ld_n);

    // Same-address conflicts: the younger result survives, and pipe results beat queued ones.
    p0_kill  = p1_valid && (p1_addr == p0_addr);
    div_kill = (p0_valid && (p0_addr == div_addr)) || (p1_valid && (p1_addr == div_addr));
    h1_kill  = (p0_valid && (p0_addr == h1_addr)) || (p1_valid && (p1_addr == h1_addr)) ||
               (div_gnt && (div_addr == h1_addr));
    h0_kill  = (p0_valid && (p0_addr == h0_addr)) || (p1_valid && (p1_addr == h0_addr)) ||
               ((ld_n == 2'd2) && (h1_addr == h0_addr)) ||
               (div_gnt && (div_addr == h0_addr));

    p0_pkt  = mk_pkt(p0_valid && !p0_kill, p0_addr, p0_data);
    p1_pkt  = mk_pkt(p1_valid, p1_addr, p1_data);
    h0_pkt  = mk_pkt((ld_n != 2'd0) && !h0_kill, h0_addr, h0_data);
    h1_pkt  = mk_pkt((ld_n == 2'd2) && !h1_kill, h1_addr, h1_data);
    div_pkt = mk_pkt(div_gnt && !div_kill, div_addr, div_data);

    // cand0/cand1: first and second granted non-pipe results, in priority order.
    cand0 = (ld_n != 2'd0) ? h0_pkt : div_pkt;
    cand1 = '0;
    if (ld_n == 2'd2)      cand1 = h1_pkt;
    else if (ld_n == 2'd1) cand1 = div_pkt;

    w0_nx = p0_valid ? p0_pkt : cand0;
    w1_nx = p1_valid ? p1_pkt : (p0_valid ? cand0 : cand1);
  end

  assign div_ready = div_gnt;

  // Address/data flops only load on a real write, so idle ports do not toggle the wide data bus.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wen0   <= 1'b0;
      waddr0 <= '0;
      wd0    <= '0;
      wen1   <= 1'b0;
      waddr1 <= '0;
      wd1    <= '0;
    end else begin
      wen0 <= w0_nx.valid;
      wen1 <= w1_nx.valid;
      if (w0_nx.valid) begin
        waddr0 <= w0_nx.addr;
        wd0    <= w0_nx.data;
      end
      if (w1_nx.valid) begin
        waddr1 <= w1_nx.addr;
        wd1    <= w1_nx.data;
      end
    end
  end

`ifdef FPR_WB_SCOREBOARD_EN
  logic [31:1] busy_nx;
  logic        unused_iss;

  assign unused_iss = iss_ld;

  // A granted long-latency result clears its bit whether it is written or squashed; a new issue
  // to the same register in that cycle re-arms it.
  always_comb begin
    busy_nx = fpr_busy;
    for (int i = 1; i < 32; i++) begin
      if (((ld_n != 2'd0) && (h0_addr == 5'(i))) ||
          ((ld_n == 2'd2) && (h1_addr == 5'(i))) ||
          (div_gnt && (div_addr == 5'(i))))
        busy_nx[i] = 1'b0;
      if (iss_valid && (iss_addr == 5'(i)))
        busy_nx[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) fpr_busy <= '0;
    else        fpr_busy <= busy_nx;
  end
`else
  logic unused_iss;

  assign unused_iss = ^{iss_valid, iss_ld, iss_addr};
  assign fpr_busy   = '0;
`endif

endmodule

// File: tb/tb_dec_fpr_wb_arb.sv
// Directed self-checking bench for dec_fpr_wb_arb.
// Inputs change 1 time unit after a rising edge; registered outputs are sampled 1 unit after the next edge.
// Scoreboard expectations follow whether FPR_WB_SCOREBOARD_EN is defined for the build.
module tb_dec_fpr_wb_arb;
  import fpr_wb_pkg::*;

`ifdef FPR_WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_l;
  logic            p0_valid, p1_valid, div_valid, ld_valid, iss_valid, iss_ld;
  logic [4:0]      p0_addr, p1_addr, div_addr, ld_addr, iss_addr;
  logic [FLEN-1:0] p0_data, p1_data, div_data, ld_data;
  logic            div_ready, ld_full, wen0, wen1;
  logic [4:0]      waddr0, waddr1;
  logic [FLEN-1:0] wd0, wd1;
  logic [31:1]     fpr_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dec_fpr_wb_arb dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .p0_valid  (p0_valid),
    .p0_addr   (p0_addr),
    .p0_data   (p0_data),
    .p1_valid  (p1_valid),
    .p1_addr   (p1_addr),
    .p1_data   (p1_data),
    .div_valid (div_valid),
    .div_addr  (div_addr),
    .div_data  (div_data),
    .div_ready (div_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_full   (ld_full),
    .wen0      (wen0),
    .waddr0    (waddr0),
    .wd0       (wd0),
    .wen1      (wen1),
    .waddr1    (waddr1),
    .wd1       (wd1),
    .fpr_busy  (fpr_busy),
    .iss_valid (iss_valid),
    .iss_ld    (iss_ld),
    .iss_addr  (iss_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_valid = 0; p0_addr = 0; p0_data = 0;
    p1_valid = 0; p1_addr = 0; p1_data = 0;
    div_valid = 0; div_addr = 0; div_data = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0;
    iss_valid = 0; iss_ld = 0; iss_addr = 0;
  endtask

  task automatic pipes(input logic [4:0] a0, input logic [FLEN-1:0] d0,
                       input logic [4:0] a1, input logic [FLEN-1:0] d1);
    p0_valid = 1; p0_addr = a0; p0_data = d0;
    p1_valid = 1; p1_addr = a1; p1_data = d1;
  endtask

  initial begin
    rst_l = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen0", wen0, 0);
    chk("rst_wen1", wen1, 0);
    chk("rst_waddr0", waddr0, 0);
    chk("rst_waddr1", waddr1, 0);
    chk("rst_wd0", wd0, 0);
    chk("rst_wd1", wd1, 0);
    chk("rst_ld_full", ld_full, 0);
    chk("rst_busy", fpr_busy, 0);
    rst_l = 1;
    step();

    // Both pipes write, divider must wait.
    pipes(5'd3, 32'hA000_0003, 5'd4, 32'hB000_0004);
    div_valid = 1; div_addr = 5'd10; div_data = 32'hD000_000A;
    #1 chk("t1_div_ready", div_ready, 0);
    step();
    chk("t1_wen0", wen0, 1);
    chk("t1_waddr0", waddr0, 3);
    chk("t1_wd0", wd0, 32'hA000_0003);
    chk("t1_wen1", wen1, 1);
    chk("t1_waddr1", waddr1, 4);
    chk("t1_wd1", wd1, 32'hB000_0004);

    // Same destination on both pipes: younger p1 wins.
    pipes(5'd5, 32'h1111_1111, 5'd5, 32'h2222_2222);
    #1 chk("t2_div_ready", div_ready, 0);
    step();
    chk("t2_wen0", wen0, 0);
    chk("t2_wen1", wen1, 1);
    chk("t2_waddr1", waddr1, 5);
    chk("t2_wd1", wd1, 32'h2222_2222);

    // Pipes idle: waiting divider result takes port 0.
    p0_valid = 0; p1_valid = 0;
    #1 chk("t2b_div_ready", div_ready, 1);
    step();
    div_valid = 0;
    chk("t2b_wen0", wen0, 1);
    chk("t2b_waddr0", waddr0, 10);
    chk("t2b_wd0", wd0, 32'hD000_000A);
    chk("t2b_wen1", wen1, 0);

    // Writes to f0 are consumed without a write enable.
    p0_valid = 1; p0_addr = 5'd0; p0_data = 32'h0000_00FF;
    step();
    p0_valid = 0;
    chk("a0_wen0", wen0, 0);
    chk("a0_wen1", wen1, 0);

    // Fill the load FIFO while both pipes hold the ports.
    for (int i = 1; i <= 4; i++) begin
      pipes(5'd20, 32'h5000_0020, 5'd21, 32'h5000_0021);
      ld_valid = 1; ld_addr = 5'(i); ld_data = 32'h1D00_0000 + 32'(i);
      step();
      if (i == 3) chk("t3_not_full", ld_full, 0);
      if (i == 4) chk("t3_full", ld_full, 1);
    end
    idle();
    step();
    chk("t3_wen0_a", wen0, 1);
    chk("t3_waddr0_a", waddr0, 1);
    chk("t3_wd0_a", wd0, 32'h1D00_0001);
    chk("t3_wen1_a", wen1, 1);
    chk("t3_waddr1_a", waddr1, 2);
    chk("t3_wd1_a", wd1, 32'h1D00_0002);
    chk("t3_full_after_drain", ld_full, 0);
    step();
    chk("t3_waddr0_b", waddr0, 3);
    chk("t3_wd0_b", wd0, 32'h1D00_0003);
    chk("t3_waddr1_b", waddr1, 4);
    chk("t3_wd1_b", wd1, 32'h1D00_0004);
    step();
    chk("t3_empty_wen0", wen0, 0);
    chk("t3_empty_wen1", wen1, 0);

    // A load is not written in its arrival cycle's grant; then FIFO head beats the divider.
    ld_valid = 1; ld_addr = 5'd8; ld_data = 32'hE000_0008;
    step();
    ld_valid = 0;
    chk("t4_not_same_cycle0", wen0, 0);
    chk("t4_not_same_cycle1", wen1, 0);
    p0_valid = 1; p0_addr = 5'd11; p0_data = 32'h5000_0011;
    div_valid = 1; div_addr = 5'd7; div_data = 32'hD000_0007;
    #1 chk("t4_div_ready0", div_ready, 0);
    step();
    chk("t4_waddr0", waddr0, 11);
    chk("t4_wen1", wen1, 1);
    chk("t4_waddr1", waddr1, 8);
    chk("t4_wd1", wd1, 32'hE000_0008);
    p0_valid = 0;
    #1 chk("t4_div_ready1", div_ready, 1);
    step();
    div_valid = 0;
    chk("t4_wen0_div", wen0, 1);
    chk("t4_waddr0_div", waddr0, 7);
    chk("t4_wd0_div", wd0, 32'hD000_0007);
    chk("t4_wen1_div", wen1, 0);

    // Queued load colliding with a pipe write is consumed and dropped.
    ld_valid = 1; ld_addr = 5'd6; ld_data = 32'hE000_0006;
    step();
    ld_valid = 0;
    p0_valid = 1; p0_addr = 5'd6; p0_data = 32'h5000_0006;
    step();
    p0_valid = 0;
    chk("pc_wen0", wen0, 1);
    chk("pc_wd0", wd0, 32'h5000_0006);
    chk("pc_wen1", wen1, 0);
    step();
    chk("pc_popped_wen0", wen0, 0);
    chk("pc_popped_wen1", wen1, 0);

    // FIFO head and divider to the same register: divider wins.
    ld_valid = 1; ld_addr = 5'd13; ld_data = 32'hE000_0013;
    step();
    ld_valid = 0;
    div_valid = 1; div_addr = 5'd13; div_data = 32'hD000_0013;
    #1 chk("fd_div_ready", div_ready, 1);
    step();
    div_valid = 0;
    chk("fd_wen0", wen0, 0);
    chk("fd_wen1", wen1, 1);
    chk("fd_waddr1", waddr1, 13);
    chk("fd_wd1", wd1, 32'hD000_0013);

    // Scoreboard: set on issue, cleared with the write.
    iss_valid = 1; iss_ld = 0; iss_addr = 5'd9;
    step();
    iss_valid = 0;
    chk("t5_busy9_set", fpr_busy[9], SB);
    div_valid = 1; div_addr = 5'd9; div_data = 32'hD000_0009;
    step();
    div_valid = 0;
    chk("t5_wen0", wen0, 1);
    chk("t5_waddr0", waddr0, 9);
    chk("t5_busy9_clr", fpr_busy[9], 0);

    // Re-issue in the same cycle as the clearing write keeps the bit set.
    iss_valid = 1; iss_addr = 5'd12;
    step();
    div_valid = 1; div_addr = 5'd12; div_data = 32'hD000_0012;
    step();
    idle();
    chk("sw_waddr0", waddr0, 12);
    chk("sw_busy12", fpr_busy[12], SB);

    // Load destination: busy until the queued return is written.
    iss_valid = 1; iss_ld = 1; iss_addr = 5'd14;
    step();
    idle();
    ld_valid = 1; ld_addr = 5'd14; ld_data = 32'hE000_0014;
    step();
    ld_valid = 0;
    chk("ld_busy14_set", fpr_busy[14], SB);
    step();
    chk("ld_waddr0", waddr0, 14);
    chk("ld_busy14_clr", fpr_busy[14], 0);

    // Reset with three queued loads.
    for (int i = 1; i <= 3; i++) begin
      pipes(5'd22, 32'h5000_0022, 5'd23, 32'h5000_0023);
      ld_valid = 1; ld_addr = 5'(i); ld_data = 32'h2D00_0000 + 32'(i);
      step();
    end
    chk("t6_pre_wen0", wen0, 1);
    idle();
    #2 rst_l = 0;
    #1;
    chk("t6_wen0", wen0, 0);
    chk("t6_wen1", wen1, 0);
    chk("t6_waddr0", waddr0, 0);
    chk("t6_wd0", wd0, 0);
    chk("t6_waddr1", waddr1, 0);
    chk("t6_wd1", wd1, 0);
    chk("t6_ld_full", ld_full, 0);
    chk("t6_busy", fpr_busy, 0);
    step();
    rst_l = 1;
    step();
    chk("t6_post_wen0_a", wen0, 0);
    chk("t6_post_wen1_a", wen1, 0);
    step();
    chk("t6_post_wen0_b", wen0, 0);
    chk("t6_post_wen1_b", wen1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
